ieee754_to_decimal: RTL and testbench
=====================================

IEEE754_TO_DECIMAL -- requirements
Module: ieee754_to_decimal

Interface
REQ-001 SHALL have ports, one clock domain; reset synchronous, active-low:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous active-low reset
- ieee754  in  32  single-precision operand
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept operand
- decimal  out  32  signed two's-complement result, truncated toward zero
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- overflow  out  1  result saturated
- nan  out  1  operand was NaN
- inexact  out  1  nonzero fraction bits discarded

Function
REQ-002 SHALL run a state machine with states IDLE, DECODE, SHIFT, SIGN and DONE.
REQ-003 IDLE: in_ready=1; on in_valid&&in_ready, SHALL latch ieee754 and go to DECODE; in_ready=0 in every other state.
REQ-004 DECODE SHALL split s=bit31, e=bits30:23, m=bits22:0, with unbiased exponent x=e-127.
REQ-005 DECODE classification SHALL be:
- e=255, m!=0 -> result 0, nan=1
- e=255, m=0 -> saturate, overflow=1
- e<127, including zero/denormal -> result 0; inexact=1 iff e!=0 or m!=0
- x>=31 -> saturate, overflow=1; exception s=1,x=31,m=0 -> 0x80000000, no flag
- otherwise -> normal
REQ-006 Saturation value SHALL be 0x7FFFFFFF for s=0 and 0x80000000 for s=1.
REQ-007 Normal operands SHALL load magnitude={8'b0,1'b1,m} and shift count k=|x-23|, direction left if x>=23 else right.
REQ-008 SHIFT SHALL move magnitude one bit per cycle and decrement k; exit to SIGN when k reaches 0.
REQ-009 When k=0 or the operand is special, DECODE SHALL go directly to SIGN.
REQ-010 Right shifts SHALL OR each discarded bit into a sticky inexact.
REQ-011 SIGN SHALL two's-complement-negate the magnitude when s=1 and the case is normal or zero, then go to DONE.
REQ-012 Latency: out_valid SHALL first be high exactly k+2 rising edges after the accepting edge (k=0 for specials).
REQ-013 DONE: out_valid=1; decimal and flags SHALL be stable while out_ready=0.
REQ-014 On out_valid&&out_ready the block SHALL return to IDLE; the next accept is possible one cycle later (no overlap).
REQ-015 in_valid while busy SHALL be ignored; no operand is lost because in_ready=0.
REQ-016 Flags SHALL be valid only with out_valid and are cleared on each accept.

Reset
REQ-017 rst_n=0 at a rising edge SHALL force:
- state IDLE
- in_ready=1
- out_valid=0
- decimal=0, overflow=0, nan=0, inexact=0
- internal magnitude and k cleared
REQ-018 Reset asserted mid-operation (any state) SHALL abandon the operand with no out_valid pulse.

Structure
REQ-019 Shared package ieee754_pkg SHALL hold:
- BIAS=127, EXP_W=8, MAN_W=23, INT_W=32
- state encoding
- INT_MAX and INT_MIN constants
REQ-020 One combinational sub-module ieee754_classify SHALL hold the REQ-004/005 unpack/classify logic; shifter, FSM and sign logic stay in ieee754_to_decimal.

Verification
REQ-021 Directed scenarios:
- 0x3F800000 -> 0x00000001, no flags, out_valid at accept+25.
- 0x449A4000 -> 1234 at accept+15; 0xC1200000 -> 0xFFFFFFF6 (-10), no flags.
- 0x4B000000 -> 8388608 at accept+2 (k=0); 0x3FC00000 (1.5) -> 1 with inexact=1; 0xBF000000 (-0.5) -> 0 with inexact=1.
- 0x4F000000 -> 0x7FFFFFFF with overflow=1; 0xCF000000 -> 0x80000000 with overflow=0; 0xFF800000 -> 0x80000000 with overflow=1; 0x7FC00000 -> 0 with nan=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> decimal/flags unchanged, in_ready=0; in_valid pulsed with another operand meanwhile is ignored.
- Reset: pulse rst_n=0 during SHIFT -> next edge IDLE, in_ready=1, all outputs 0; a fresh 0x40400000 then yields 3.

Source files
------------

// File: rtl/ieee754_pkg.sv
// Shared constants, state encoding and operand classes for the
// single-precision float to 32-bit integer converter.
package ieee754_pkg;

   localparam int unsigned BIAS  = 127;
   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;
   localparam int unsigned INT_W = 32;

   localparam logic [INT_W-1:0] INT_MAX = 32'h7FFF_FFFF;
   localparam logic [INT_W-1:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_SHIFT,
      ST_SIGN,
      ST_DONE
   } state_e;

   typedef enum logic [2:0] {
      CLS_NORMAL,
      CLS_ZERO,
      CLS_NAN,
      CLS_SAT,
      CLS_MIN
   } cls_e;

endpackage

// File: rtl/ieee754_classify.sv
// Combinational unpack of a single-precision operand into class, initial
// magnitude and shift request for the serial shifter.
module ieee754_classify
   import ieee754_pkg::*;
(
   input  logic [INT_W-1:0] operand,
   output logic             sign,
   output cls_e             cls,
   output logic [4:0]       shift_k,
   output logic             shift_left,
   output logic [INT_W-1:0] mag_init,
   output logic             inexact_init
);

   localparam logic [EXP_W-1:0] EXP_ONE    = EXP_W'(BIAS);
   localparam logic [EXP_W-1:0] EXP_ALIGN  = EXP_W'(BIAS + MAN_W);
   localparam logic [EXP_W-1:0] EXP_OVF    = EXP_W'(BIAS + INT_W - 1);
   localparam logic [EXP_W-1:0] EXP_SPECIAL = '1;

   logic [EXP_W-1:0] exp_f;
   logic [MAN_W-1:0] man_f;

   always_comb begin
      sign         = operand[INT_W-1];
      exp_f        = operand[INT_W-2 -: EXP_W];
      man_f        = operand[MAN_W-1:0];
      cls          = CLS_NORMAL;
      shift_k      = '0;
      shift_left   = 1'b0;
      mag_init     = {8'b0, 1'b1, man_f};
      inexact_init = 1'b0;

      if (exp_f == EXP_SPECIAL) begin
         if (man_f != '0) begin
            cls      = CLS_NAN;
            mag_init = '0;
         end else begin
            cls      = CLS_SAT;
            mag_init = sign ? INT_MIN : INT_MAX;
         end
      end else if (exp_f < EXP_ONE) begin
         cls          = CLS_ZERO;
         mag_init     = '0;
         inexact_init = (exp_f != '0) || (man_f != '0);
      end else if (exp_f >= EXP_OVF) begin
         // -2^31 is exactly representable, so it is not an overflow
         if (sign && (exp_f == EXP_OVF) && (man_f == '0)) begin
            cls = CLS_MIN;
         end else begin
            cls = CLS_SAT;
         end
         mag_init = (cls == CLS_SAT && !sign) ? INT_MAX : INT_MIN;
      end else if (exp_f >= EXP_ALIGN) begin
         shift_left = 1'b1;
         shift_k    = 5'(exp_f - EXP_ALIGN);
      end else begin
         shift_k    = 5'(EXP_ALIGN - exp_f);
      end
   end

endmodule

// File: rtl/ieee754_to_decimal.sv
// Serial float-to-int converter: one magnitude bit shifted per cycle,
// truncating toward zero with saturation and NaN/inexact reporting.
module ieee754_to_decimal
   import ieee754_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [INT_W-1:0] ieee754,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [INT_W-1:0] decimal,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   output logic             nan,
   output logic             inexact
);

   state_e           state_q, state_d;
   logic [INT_W-1:0] opnd_q, opnd_d;
   logic [INT_W-1:0] mag_q, mag_d;
   logic [4:0]       k_q, k_d;
   logic             left_q, left_d;
   logic             neg_q, neg_d;
   logic             ovf_q, ovf_d;
   logic             nan_q, nan_d;
   logic             inx_q, inx_d;

   logic             cls_sign;
   cls_e             cls;
   logic [4:0]       cls_k;
   logic             cls_left;
   logic [INT_W-1:0] cls_mag;
   logic             cls_inexact;

   ieee754_classify u_classify (
      .operand      (opnd_q),
      .sign         (cls_sign),
      .cls          (cls),
      .shift_k      (cls_k),
      .shift_left   (cls_left),
      .mag_init     (cls_mag),
      .inexact_init (cls_inexact)
   );

   always_comb begin
      state_d = state_q;
      opnd_d  = opnd_q;
      mag_d   = mag_q;
      k_d     = k_q;
      left_d  = left_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      nan_d   = nan_q;
      inx_d   = inx_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               opnd_d  = ieee754;
               mag_d   = '0;
               k_d     = '0;
               left_d  = 1'b0;
               neg_d   = 1'b0;
               ovf_d   = 1'b0;
               nan_d   = 1'b0;
               inx_d   = 1'b0;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            mag_d   = cls_mag;
            k_d     = cls_k;
            left_d  = cls_left;
            inx_d   = cls_inexact;
            ovf_d   = (cls == CLS_SAT);
            nan_d   = (cls == CLS_NAN);
            // saturated and -2^31 results are already in final form
            neg_d   = cls_sign && ((cls == CLS_NORMAL) || (cls == CLS_ZERO));
            state_d = ((cls == CLS_NORMAL) && (cls_k != '0)) ? ST_SHIFT : ST_SIGN;
         end
         ST_SHIFT: begin
            if (left_q) begin
               mag_d = mag_q << 1;
            end else begin
               mag_d = mag_q >> 1;
               inx_d = inx_q | mag_q[0];
            end
            k_d = k_q - 5'd1;
            if (k_q == 5'd1) begin
               state_d = ST_SIGN;
            end
         end
         ST_SIGN: begin
            if (neg_q) begin
               mag_d = ~mag_q + 1'b1;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         opnd_q  <= '0;
         mag_q   <= '0;
         k_q     <= '0;
         left_q  <= 1'b0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
         nan_q   <= 1'b0;
         inx_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opnd_q  <= opnd_d;
         mag_q   <= mag_d;
         k_q     <= k_d;
         left_q  <= left_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
         nan_q   <= nan_d;
         inx_q   <= inx_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign decimal   = out_valid ? mag_q : '0;
   assign overflow  = out_valid & ovf_q;
   assign nan       = out_valid & nan_q;
   assign inexact   = out_valid & inx_q;

endmodule

// File: tb/tb_ieee754_to_decimal.sv
// Self-checking bench for ieee754_to_decimal: directed cases, randomized
// operands against a real-arithmetic reference, backpressure and reset.
module tb_ieee754_to_decimal;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ieee754 = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] decimal;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        overflow;
   logic        nan;
   logic        inexact;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ieee754_to_decimal dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ieee754   (ieee754),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .decimal   (decimal),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overflow  (overflow),
      .nan       (nan),
      .inexact   (inexact)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: evaluate the operand as a real number, then truncate/saturate.
   function automatic void ref_model(input logic [31:0] op, output logic [31:0] d,
                                     output logic o, output logic n, output logic ix,
                                     output int lat);
      int  e;
      int  m;
      int  t;
      real v;
      e   = {24'b0, op[30:23]};
      m   = {9'b0, op[22:0]};
      d   = '0;
      o   = 1'b0;
      n   = 1'b0;
      ix  = 1'b0;
      lat = 2;
      if (e == 255) begin
         if (m != 0) n = 1'b1;
         else begin
            o = 1'b1;
            d = op[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         end
         return;
      end
      if (e == 0) v = real'(m) * (2.0 ** real'(-149));
      else        v = (real'(m) + 8388608.0) * (2.0 ** real'(e - 150));
      if (op[31]) v = -v;
      if (v >= 2147483648.0) begin
         o = 1'b1;
         d = 32'h7FFF_FFFF;
      end else if (v < -2147483648.0) begin
         o = 1'b1;
         d = 32'h8000_0000;
      end else begin
         t  = $rtoi(v);
         d  = t;
         ix = (v != $itor(t));
      end
      if (e >= 127 && e <= 157) lat = 2 + ((e >= 150) ? (e - 150) : (150 - e));
   endfunction

   task automatic start_op(input logic [31:0] op, input string tag);
      @(negedge clk);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      ieee754  = op;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ieee754  = $urandom;
   endtask

   task automatic wait_done(input int lat, input string tag);
      int cnt;
      cnt = 0;
      while (!out_valid && cnt < 80) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check({tag, "_latency"}, 32'(cnt), 32'(lat));
   endtask

   task automatic check_res(input logic [31:0] d, input logic o, input logic n,
                            input logic ix, input string tag);
      check({tag, "_decimal"},  decimal, d);
      check({tag, "_overflow"}, 32'(overflow), 32'(o));
      check({tag, "_nan"},      32'(nan), 32'(n));
      check({tag, "_inexact"},  32'(inexact), 32'(ix));
   endtask

   task automatic release_op(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_op(input logic [31:0] op, input logic [31:0] d, input logic o,
                         input logic n, input logic ix, input int lat, input string tag);
      start_op(op, tag);
      wait_done(lat, tag);
      check_res(d, o, n, ix, tag);
      release_op(tag);
   endtask

   initial begin
      logic [31:0] op;
      logic [31:0] rd;
      logic        ro, rn, rix;
      int          rlat;
      int          phantom;

      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check_res('0, 1'b0, 1'b0, 1'b0, "reset");
      @(negedge clk);
      rst_n = 1'b1;

      run_op(32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 25, "one");
      run_op(32'h449A_4000, 32'd1234,      1'b0, 1'b0, 1'b0, 15, "n1234");
      run_op(32'hC120_0000, 32'hFFFF_FFF6, 1'b0, 1'b0, 1'b0, 22, "neg10");
      run_op(32'h4B00_0000, 32'd8388608,   1'b0, 1'b0, 1'b0, 2,  "k0");
      run_op(32'h3FC0_0000, 32'd1,         1'b0, 1'b0, 1'b1, 25, "p1_5");
      run_op(32'hBF00_0000, 32'd0,         1'b0, 1'b0, 1'b1, 2,  "m0_5");
      run_op(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 2,  "pos_ovf");
      run_op(32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2,  "int_min");
      run_op(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 2,  "neg_inf");
      run_op(32'h7FC0_0000, 32'd0,         1'b0, 1'b1, 1'b0, 2,  "qnan");
      run_op(32'h0000_0000, 32'd0,         1'b0, 1'b0, 1'b0, 2,  "zero");
      run_op(32'h0000_0001, 32'd0,         1'b0, 1'b0, 1'b1, 2,  "denorm");
      run_op(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 1'b0, 9,  "max_x30");

      for (int i = 0; i < 40; i++) begin
         op = $urandom;
         if ($urandom_range(3, 0) != 0) op[30:23] = 8'($urandom_range(165, 110));
         ref_model(op, rd, ro, rn, rix, rlat);
         run_op(op, rd, ro, rn, rix, rlat, $sformatf("rand%0d_%h", i, op));
      end

      start_op(32'h449A_4000, "bp");
      wait_done(15, "bp");
      check_res(32'd1234, 1'b0, 1'b0, 1'b0, "bp_first");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = (i == 3);
         ieee754  = 32'h3F80_0000;
         @(posedge clk);
         #1;
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_ready", 32'(in_ready), 32'd0);
         check_res(32'd1234, 1'b0, 1'b0, 1'b0, "bp_hold");
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_op("bp");
      phantom = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (out_valid) phantom++;
      end
      check("bp_ignored_operand", 32'(phantom), 32'd0);

      start_op(32'h3F80_0000, "rst");
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check_res('0, 1'b0, 1'b0, 1'b0, "rst");
      @(negedge clk);
      rst_n = 1'b1;
      phantom = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (out_valid) phantom++;
      end
      check("rst_no_pulse", 32'(phantom), 32'd0);
      run_op(32'h4040_0000, 32'd3, 1'b0, 1'b0, 1'b0, 24, "after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
